// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for mem_access_unit: FSM states, funct3 access
// codes and helpers that decode access size and signedness.
package mem_access_unit_pkg;

    localparam int DEF_XLEN   = 32;
    localparam int DEF_ADDR_W = 32;

    typedef logic [DEF_ADDR_W-1:0] addr_t;
    typedef logic [DEF_XLEN-1:0]   data_t;
    typedef logic [31:0]           instr_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2,
        S_DONE = 2'd3
    } mau_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Access size in bytes; doubles fall back to words on a 32-bit datapath.
    function automatic logic [3:0] f3_size(input logic [2:0] f3, input logic is64);
        logic [3:0] sz;
        case (f3)
            F3_LB, F3_LBU: sz = 4'd1;
            F3_LH, F3_LHU: sz = 4'd2;
            F3_LD:         sz = is64 ? 4'd8 : 4'd4;
            default:       sz = 4'd4;
        endcase
        return sz;
    endfunction

    function automatic logic f3_signed(input logic [2:0] f3);
        logic s;
        case (f3)
            F3_LBU, F3_LHU, F3_LWU: s = 1'b0;
            default:                s = 1'b1;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// load_store_align: combinational store lane/strobe steering, load lane
// extraction with sign/zero extension, and misalignment detection.
module load_store_align
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int NB = XLEN / 8,
    localparam int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [2:0]       funct3,
    input  logic [OFF_W-1:0] offset,
    input  logic             addr_bit2,
    input  logic [XLEN-1:0]  store_data,
    input  logic [XLEN-1:0]  rdata,
    output logic [XLEN-1:0]  wdata,
    output logic [NB-1:0]    wstrb,
    output logic [XLEN-1:0]  load_data,
    output logic [31:0]      instr_word,
    output logic             misaligned
);

    logic [3:0]              size_s;
    logic                    sign_s;
    logic [OFF_W+2:0]        lane_sh_s;
    logic [6:0]              ext_sh_s;
    logic [NB-1:0]           size_mask_s;
    logic [XLEN-1:0]         lane_s;
    logic [XLEN-1:0]         top_s;
    logic signed [XLEN-1:0]  sext_s;
    logic [XLEN-1:0]         zext_s;
    logic [XLEN-1:0]         ir_lane_s;

    // Lane steering and extension; bytes shifted past the XLEN boundary drop out naturally.
    always_comb begin
        size_s    = f3_size(funct3, XLEN == 64);
        sign_s    = f3_signed(funct3);
        lane_sh_s = {offset, 3'b000};
        ext_sh_s  = 7'(XLEN) - {size_s, 3'b000};
        case (size_s)
            4'd1:    size_mask_s = NB'(1);
            4'd2:    size_mask_s = NB'(3);
            4'd8:    size_mask_s = NB'(255);
            default: size_mask_s = NB'(15);
        endcase
        misaligned = (offset & OFF_W'(size_s - 4'd1)) != {OFF_W{1'b0}};
        wdata      = store_data << lane_sh_s;
        wstrb      = size_mask_s << offset;
        lane_s     = rdata >> lane_sh_s;
        // Push the field to the top, then shift back to extend it.
        top_s      = lane_s << ext_sh_s;
        sext_s     = $signed(top_s) >>> ext_sh_s;
        zext_s     = top_s >> ext_sh_s;
        load_data  = sign_s ? sext_s : zext_s;
        ir_lane_s  = (XLEN == 64 && addr_bit2) ? (rdata >> 6'd32) : rdata;
        instr_word = ir_lane_s[31:0];
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle IDLE/REQ/RSP/DONE access engine to a unified
// memory. Build option MEM_MISALIGN_TRAP_EN traps misaligned accesses.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                adr_src,
    input  logic [ADDR_W-1:0]   pc,
    input  logic [ADDR_W-1:0]   result_addr,
    input  logic                write_en,
    input  logic                ir_write,
    input  logic [2:0]          funct3,
    input  logic [XLEN-1:0]     write_data,
    output logic [31:0]         instr,
    output logic [XLEN-1:0]     data,
    output logic                busy,
    output logic                done,
    output logic                fault,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_we,
    output logic [XLEN-1:0]     mem_req_wdata,
    output logic [XLEN/8-1:0]   mem_req_wstrb,
    input  logic                mem_rsp_valid,
    input  logic [XLEN-1:0]     mem_rsp_rdata
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    mau_state_t         state_r, state_n;
    logic [CNT_W-1:0]   cnt_r, cnt_n;
    logic [OFF_W-1:0]   off_r;
    logic               bit2_r;
    logic               we_r;
    logic               irw_r;
    logic [2:0]         f3_r;
    logic [ADDR_W-1:0]  req_addr_r;
    logic               req_we_r;
    logic [XLEN-1:0]    req_wdata_r;
    logic [NB-1:0]      req_wstrb_r;
    logic               req_valid_r;
    logic               busy_r;
    logic               done_r;
    logic               fault_r;
    logic [XLEN-1:0]    data_r;
    logic [31:0]        instr_r;

    logic               latch_s;
    logic               capture_s;
    logic               fault_n;
    logic [ADDR_W-1:0]  eff_addr_s;
    logic [OFF_W-1:0]   a_off_s;
    logic               a_bit2_s;
    logic [2:0]         a_f3_s;
    logic [XLEN-1:0]    wdata_s;
    logic [NB-1:0]      wstrb_s;
    logic [XLEN-1:0]    load_s;
    logic [31:0]        iword_s;
    logic               misaligned_s;

    // The aligner sees the live inputs in IDLE and the latched access afterwards.
    always_comb begin
        eff_addr_s = adr_src ? result_addr : pc;
        if (state_r == S_IDLE) begin
            a_off_s  = eff_addr_s[OFF_W-1:0];
            a_bit2_s = eff_addr_s[2];
            a_f3_s   = funct3;
        end else begin
            a_off_s  = off_r;
            a_bit2_s = bit2_r;
            a_f3_s   = f3_r;
        end
    end

    load_store_align #(.XLEN(XLEN)) u_align (
        .funct3     (a_f3_s),
        .offset     (a_off_s),
        .addr_bit2  (a_bit2_s),
        .store_data (write_data),
        .rdata      (mem_rsp_rdata),
        .wdata      (wdata_s),
        .wstrb      (wstrb_s),
        .load_data  (load_s),
        .instr_word (iword_s),
        .misaligned (misaligned_s)
    );

`ifndef MEM_MISALIGN_TRAP_EN
    logic unused_misalign_s;
    assign unused_misalign_s = misaligned_s;
`endif

    // Next-state, timeout and capture decisions.
    always_comb begin
        state_n   = state_r;
        cnt_n     = cnt_r;
        latch_s   = 1'b0;
        capture_s = 1'b0;
        fault_n   = 1'b0;
        case (state_r)
            S_IDLE: begin
                cnt_n = {CNT_W{1'b0}};
                if (start) begin
`ifdef MEM_MISALIGN_TRAP_EN
                    if (misaligned_s) begin
                        state_n = S_DONE;
                        fault_n = 1'b1;
                    end else begin
                        latch_s = 1'b1;
                        state_n = S_REQ;
                    end
`else
                    latch_s = 1'b1;
                    state_n = S_REQ;
`endif
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_n = S_RSP;
                end else begin
                    state_n = S_REQ;
                end
            end
            S_RSP: begin
                if (mem_rsp_valid) begin
                    capture_s = 1'b1;
                    state_n   = S_DONE;
                end else if (TIMEOUT_CYCLES != 0 && cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    fault_n = 1'b1;
                    state_n = S_DONE;
                end else begin
                    cnt_n = cnt_r + 1'b1;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // State, counter and status flags, registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            req_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            fault_r     <= 1'b0;
        end else begin
            state_r     <= state_n;
            cnt_r       <= cnt_n;
            req_valid_r <= (state_n == S_REQ);
            busy_r      <= (state_n != S_IDLE);
            done_r      <= (state_n == S_DONE);
            fault_r     <= fault_n;
        end
    end

    // Access latch, request fields and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            off_r       <= {OFF_W{1'b0}};
            bit2_r      <= 1'b0;
            we_r        <= 1'b0;
            irw_r       <= 1'b0;
            f3_r        <= 3'b000;
            req_addr_r  <= {ADDR_W{1'b0}};
            req_we_r    <= 1'b0;
            req_wdata_r <= {XLEN{1'b0}};
            req_wstrb_r <= {NB{1'b0}};
            data_r      <= {XLEN{1'b0}};
            instr_r     <= 32'h0000_0000;
        end else begin
            if (latch_s) begin
                off_r       <= eff_addr_s[OFF_W-1:0];
                bit2_r      <= eff_addr_s[2];
                we_r        <= write_en;
                irw_r       <= ir_write;
                f3_r        <= funct3;
                req_addr_r  <= {eff_addr_s[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                req_we_r    <= write_en;
                req_wdata_r <= write_en ? wdata_s : {XLEN{1'b0}};
                req_wstrb_r <= write_en ? wstrb_s : {NB{1'b0}};
            end
            if (capture_s && !we_r) begin
                data_r <= load_s;
                if (irw_r) begin
                    instr_r <= iword_s;
                end
            end
        end
    end

    assign instr         = instr_r;
    assign data          = data_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign fault         = fault_r;
    assign mem_req_valid = req_valid_r;
    assign mem_req_addr  = req_addr_r;
    assign mem_req_we    = req_we_r;
    assign mem_req_wdata = req_wdata_r;
    assign mem_req_wstrb = req_wstrb_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit (XLEN=32, TIMEOUT_CYCLES=4) with a
// configurable memory responder; follows MEM_MISALIGN_TRAP_EN if defined.
module tb_mem_access_unit;

    localparam int XLEN = 32;
    localparam int AW   = 32;
    localparam int TO   = 4;

    logic            clk, reset, start, adr_src, write_en, ir_write;
    logic [AW-1:0]   pc, result_addr;
    logic [2:0]      funct3;
    logic [XLEN-1:0] write_data;
    logic [31:0]     instr;
    logic [XLEN-1:0] data;
    logic            busy, done, fault;
    logic            mem_req_valid, mem_req_ready, mem_req_we, mem_rsp_valid;
    logic [AW-1:0]   mem_req_addr;
    logic [XLEN-1:0] mem_req_wdata, mem_rsp_rdata;
    logic [3:0]      mem_req_wstrb;

    mem_access_unit #(.XLEN(XLEN), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .adr_src(adr_src), .pc(pc),
        .result_addr(result_addr), .write_en(write_en), .ir_write(ir_write),
        .funct3(funct3), .write_data(write_data), .instr(instr), .data(data),
        .busy(busy), .done(done), .fault(fault), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata),
        .mem_req_wstrb(mem_req_wstrb), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_rdata(mem_rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;
    typedef struct packed {
        logic        fault;
        logic [31:0] data;
        logic [31:0] instr;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    int total = 0;
    int bad   = 0;

    int          cfg_ready_wait = 0;
    int          cfg_rsp_wait   = 0;
    logic [31:0] cfg_rdata      = 32'h0;
    int          rsp_cd         = -1;
    int          wait_cnt       = 0;
    bit          inject_stray   = 1'b0;

    logic [31:0] cur_data  = 32'h0;
    logic [31:0] cur_instr = 32'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic exp_req(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [3:0] st);
        req_t r;
        r.addr = a; r.we = we; r.wdata = wd; r.wstrb = st;
        req_q.push_back(r);
    endtask

    task automatic exp_rsp(input logic f, input logic [31:0] d, input logic [31:0] i);
        rsp_t r;
        r.fault = f; r.data = d; r.instr = i;
        rsp_q.push_back(r);
    endtask

    // Memory responder: optional ready backpressure, response delay, stray responses.
    initial begin
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 32'h0;
        forever begin
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            if (reset) begin
                rsp_cd = -1; wait_cnt = 0; mem_req_ready = 1'b0;
            end else begin
                if (inject_stray) begin
                    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hDEADBEEF; inject_stray = 1'b0;
                end else if (rsp_cd == 0) begin
                    mem_rsp_valid = 1'b1; mem_rsp_rdata = cfg_rdata; rsp_cd = -1;
                end else if (rsp_cd > 0) begin
                    rsp_cd--;
                end
                if (mem_req_valid) begin
                    if (wait_cnt < cfg_ready_wait) begin
                        mem_req_ready = 1'b0; wait_cnt++;
                    end else begin
                        mem_req_ready = 1'b1; wait_cnt = 0; rsp_cd = cfg_rsp_wait;
                    end
                end else begin
                    mem_req_ready = 1'b0;
                end
            end
        end
    end

    req_t er, held;
    rsp_t ep;
    bit   seen = 1'b0;

    // Monitor: pops expectations whenever a request or completion appears.
    initial begin
        forever begin
            @(negedge clk);
            if (done) begin
                if (rsp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got done=1 expected no completion");
                end else begin
                    ep = rsp_q.pop_front();
                    chk("rsp_fault", fault, ep.fault);
                    chk("rsp_data",  data,  ep.data);
                    chk("rsp_instr", instr, ep.instr);
                end
            end
            if (mem_req_valid) begin
                if (!seen) begin
                    if (req_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_req: got request addr=%0h expected none", mem_req_addr);
                    end else begin
                        er = req_q.pop_front();
                        chk("req_addr",  mem_req_addr,  er.addr);
                        chk("req_we",    mem_req_we,    er.we);
                        chk("req_wdata", mem_req_wdata, er.wdata);
                        chk("req_wstrb", mem_req_wstrb, er.wstrb);
                    end
                    held.addr = mem_req_addr; held.wdata = mem_req_wdata;
                    held.we = mem_req_we; held.wstrb = mem_req_wstrb;
                    seen = 1'b1;
                end else begin
                    chk("req_hold_addr",  mem_req_addr,  held.addr);
                    chk("req_hold_wdata", mem_req_wdata, held.wdata);
                    chk("req_hold_wstrb", mem_req_wstrb, held.wstrb);
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    task automatic access(input logic src, input logic [31:0] a, input logic we, input logic irw,
                          input logic [2:0] f3, input logic [31:0] wd, input int exp_lat,
                          input bit hold_start, input string name);
        int k;
        adr_src     = src;
        pc          = src ? 32'hFFFF_FFF0 : a;
        result_addr = src ? a : 32'hFFFF_FFF0;
        write_en    = we;
        ir_write    = irw;
        funct3      = f3;
        write_data  = wd;
        start       = 1'b1;
        @(negedge clk);
        k = 1;
        if (hold_start) begin
            @(negedge clk);
            k = 2;
        end
        start = 1'b0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL %s_timeout: got no done within %0d cycles expected done", name, k);
        end else begin
            chk({name, "_latency"}, k, exp_lat);
            chk({name, "_busy_at_done"}, busy, 1'b1);
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; adr_src = 1'b0; pc = 32'h0; result_addr = 32'h0;
        write_en = 1'b0; ir_write = 1'b0; funct3 = 3'b000; write_data = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_instr", instr, 32'h0);
        chk("reset_data",  data,  32'h0);
        chk("reset_flags", {busy, done, fault, mem_req_valid, mem_req_we}, 5'b00000);
        chk("reset_req",   {mem_req_addr, mem_req_wstrb}, 36'h0);
        reset = 1'b0;
        @(negedge clk);

        // Instruction fetch from PC.
        cfg_rdata = 32'h0050_0093;
        exp_req(32'h100, 1'b0, 32'h0, 4'b0000);
        cur_data = 32'h0050_0093; cur_instr = 32'h0050_0093;
        exp_rsp(1'b0, cur_data, cur_instr);
        access(1'b0, 32'h100, 1'b0, 1'b1, 3'b010, 32'h0, 3, 1'b0, "fetch");

        // Signed / unsigned byte load at offset 3.
        cfg_rdata = 32'h80FF_FFFF;
        exp_req(32'h200, 1'b0, 32'h0, 4'b0000);
        cur_data = 32'hFFFF_FF80;
        exp_rsp(1'b0, cur_data, cur_instr);
        access(1'b1, 32'h203, 1'b0, 1'b0, 3'b000, 32'h0, 3, 1'b0, "lb");
        exp_req(32'h200, 1'b0, 32'h0, 4'b0000);
        cur_data = 32'h0000_0080;
        exp_rsp(1'b0, cur_data, cur_instr);
        access(1'b1, 32'h203, 1'b0, 1'b0, 3'b100, 32'h0, 3, 1'b0, "lbu");

        // Half store at offset 2; start held an extra cycle must be ignored.
        cfg_rdata = 32'h0;
        exp_req(32'h300, 1'b1, 32'h1234_0000, 4'b1100);
        exp_rsp(1'b0, cur_data, cur_instr);
        access(1'b1, 32'h302, 1'b1, 1'b0, 3'b001, 32'hABCD_1234, 3, 1'b1, "sh");

        // Backpressure: ready withheld for three cycles.
        cfg_ready_wait = 3; cfg_rdata = 32'hCAFE_F00D;
        exp_req(32'h10, 1'b0, 32'h0, 4'b0000);
        cur_data = 32'hCAFE_F00D;
        exp_rsp(1'b0, cur_data, cur_instr);
        access(1'b1, 32'h10, 1'b0, 1'b0, 3'b010, 32'h0, 6, 1'b0, "lw_bp");
        cfg_ready_wait = 0;

        // Half loads at offset 2.
        cfg_rdata = 32'h8001_0000;
        exp_req(32'h20, 1'b0, 32'h0, 4'b0000);
        cur_data = 32'hFFFF_8001;
        exp_rsp(1'b0, cur_data, cur_instr);
        access(1'b1, 32'h22, 1'b0, 1'b0, 3'b001, 32'h0, 3, 1'b0, "lh");
        exp_req(32'h20, 1'b0, 32'h0, 4'b0000);
        cur_data = 32'h0000_8001;
        exp_rsp(1'b0, cur_data, cur_instr);
        access(1'b1, 32'h22, 1'b0, 1'b0, 3'b101, 32'h0, 3, 1'b0, "lhu");

        // Byte store at offset 1.
        exp_req(32'h500, 1'b1, 32'h0000_5A00, 4'b0010);
        exp_rsp(1'b0, cur_data, cur_instr);
        access(1'b1, 32'h501, 1'b1, 1'b0, 3'b000, 32'h0000_005A, 3, 1'b0, "sb");

        // Timeout with no response, then a stray response in IDLE.
        cfg_rsp_wait = -1;
        exp_req(32'h40, 1'b0, 32'h0, 4'b0000);
        exp_rsp(1'b1, cur_data, cur_instr);
        access(1'b1, 32'h40, 1'b0, 1'b1, 3'b010, 32'h0, 6, 1'b0, "timeout");
        inject_stray = 1'b1;
        repeat (4) @(negedge clk);
        chk("stray_busy",  busy,  1'b0);
        chk("stray_data",  data,  cur_data);
        chk("stray_instr", instr, cur_instr);
        cfg_rsp_wait = 0;

        // Misaligned accesses.
        cfg_rdata = 32'h1122_3344;
`ifdef MEM_MISALIGN_TRAP_EN
        exp_rsp(1'b1, cur_data, cur_instr);
        access(1'b1, 32'h401, 1'b0, 1'b0, 3'b010, 32'h0, 1, 1'b0, "lw_mis");
        exp_rsp(1'b1, cur_data, cur_instr);
        access(1'b1, 32'h403, 1'b1, 1'b0, 3'b001, 32'h0000_BEEF, 1, 1'b0, "sh_mis");
        exp_rsp(1'b1, cur_data, cur_instr);
        access(1'b1, 32'h403, 1'b0, 1'b0, 3'b001, 32'h0, 1, 1'b0, "lh_mis");
`else
        exp_req(32'h400, 1'b0, 32'h0, 4'b0000);
        cur_data = 32'h0011_2233;
        exp_rsp(1'b0, cur_data, cur_instr);
        access(1'b1, 32'h401, 1'b0, 1'b0, 3'b010, 32'h0, 3, 1'b0, "lw_mis");
        exp_req(32'h400, 1'b1, 32'hEF00_0000, 4'b1000);
        exp_rsp(1'b0, cur_data, cur_instr);
        access(1'b1, 32'h403, 1'b1, 1'b0, 3'b001, 32'h0000_BEEF, 3, 1'b0, "sh_mis");
        cfg_rdata = 32'h85FF_FFFF;
        exp_req(32'h400, 1'b0, 32'h0, 4'b0000);
        cur_data = 32'h0000_0085;
        exp_rsp(1'b0, cur_data, cur_instr);
        access(1'b1, 32'h403, 1'b0, 1'b0, 3'b001, 32'h0, 3, 1'b0, "lh_mis");
`endif

        // Reset while waiting in RSP.
        cfg_rsp_wait = -1;
        exp_req(32'h60, 1'b0, 32'h0, 4'b0000);
        adr_src = 1'b1; result_addr = 32'h60; write_en = 1'b0; ir_write = 1'b1;
        funct3 = 3'b010; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rsp_wait_busy", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_valid", mem_req_valid, 1'b0);
        chk("midreset_flags", {busy, done, fault}, 3'b000);
        chk("midreset_data",  data,  32'h0);
        chk("midreset_instr", instr, 32'h0);
        cfg_rsp_wait = 0;
        inject_stray = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_reset_busy", busy, 1'b0);
        chk("post_reset_data", data, 32'h0);
        chk("queues_drained", {32'(req_q.size()), 32'(rsp_q.size())}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
